// File: rtl/descale_result_collector.sv
// ---------------------------------------------------------------------------
// descale_result_collector
//
// Sits at the output of the descale stage. Each cycle that `done` is high, one
// finished (x, y, z, InsTag) result is captured into a small circular FIFO.
// The FIFO head is presented downstream under a valid/ready handshake. This
// lets a consumer that may stall (writeback, host interface) sit behind a
// descale pipeline that cannot stall.
//
// The FIFO is first-word-fall-through with registered outputs. The head entry
// lives in the output registers (x_result .. InsTagResult), so a result
// captured into an empty FIFO appears on the outputs on the cycle after
// `done`. No input reaches any output combinationally.
//
// Parameters:
//   DEPTH        FIFO entries. Must be a power of two and at least 2.
//
// Ports:
//   clock        rising-edge clock
//   reset        asynchronous, active-high reset
//   x_in/y_in/z_in  32-bit descaled results (opaque payload)
//   done         result strobe; one result per high cycle, cannot be stalled
//   InsTag_in    8-bit instruction tag travelling with the result
//   ResultReady  consumer takes the head entry this cycle
//   x_result/y_result/z_result/InsTagResult  head entry
//   ResultValid  head entry is valid
//   count        occupancy, 0..DEPTH
//   full         count == DEPTH
//   overflow     sticky; set when a result had to be dropped
//   tag_seq_err  (only with COLLECTOR_TAG_CHECK_EN) sticky; set when an
//                accepted tag is not the previous accepted tag + 1
//
// Optional feature macro: COLLECTOR_TAG_CHECK_EN enables the tag sequence
// checker and the tag_seq_err port. Without it the block has no checker.
// ---------------------------------------------------------------------------
module descale_result_collector #(
    parameter int DEPTH = 8
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [31:0]                x_in,
    input  logic [31:0]                y_in,
    input  logic [31:0]                z_in,
    input  logic                       done,
    input  logic [7:0]                 InsTag_in,
    input  logic                       ResultReady,
    output logic [31:0]                x_result,
    output logic [31:0]                y_result,
    output logic [31:0]                z_result,
    output logic [7:0]                 InsTagResult,
    output logic                       ResultValid,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       overflow
`ifdef COLLECTOR_TAG_CHECK_EN
    ,
    output logic                       tag_seq_err
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = 104;

    // Entry packing: {x, y, z, tag}
    logic [EW-1:0]  in_entry;
    logic [EW-1:0]  head_next;
    logic [EW-1:0]  mem [DEPTH];

    logic [AW-1:0]  wr_ptr_reg;
    logic [AW-1:0]  rd_ptr_reg;
    logic [AW-1:0]  rd_ptr_next;
    logic [AW-1:0]  wr_ptr_next;
    logic [CW-1:0]  count_next;

    logic           pop;
    logic           accept;
    logic           bypass;

    assign in_entry = {x_in, y_in, z_in, InsTag_in};

    always_comb begin
        pop         = ResultValid & ResultReady;
        // A full FIFO still accepts when the head leaves in the same cycle:
        // the slot being written is the one the popped head occupied.
        accept      = done & (~full | pop);
        count_next  = count + CW'(accept) - CW'(pop);
        rd_ptr_next = rd_ptr_reg + AW'(pop);
        wr_ptr_next = wr_ptr_reg + AW'(accept);
        // The entry that becomes head next cycle is being written right now
        // only when it lands in the slot the read pointer moves onto, i.e.
        // the FIFO is (or becomes) otherwise empty. Forward it from the
        // input; memory does not hold it yet.
        bypass      = accept && (wr_ptr_reg == rd_ptr_next);
        head_next   = bypass ? in_entry : mem[rd_ptr_next];
    end

    // Storage array: no reset, so it maps onto plain RAM. A write during
    // reset is harmless because the pointers are held at zero and the
    // occupancy at zero, so the slot is treated as empty.
    always_ff @(posedge clock) begin
        if (accept) begin
            mem[wr_ptr_reg] <= in_entry;
        end
    end

    // Control and output registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count        <= '0;
            full         <= 1'b0;
            overflow     <= 1'b0;
            ResultValid  <= 1'b0;
            x_result     <= '0;
            y_result     <= '0;
            z_result     <= '0;
            InsTagResult <= '0;
        end else begin
            wr_ptr_reg  <= wr_ptr_next;
            rd_ptr_reg  <= rd_ptr_next;
            count       <= count_next;
            full        <= (count_next == CW'(DEPTH));
            ResultValid <= (count_next != '0);
            // Outputs only move when there is a head to show; otherwise they
            // keep their last (don't-care) contents.
            if (count_next != '0) begin
                {x_result, y_result, z_result, InsTagResult} <= head_next;
            end
            if (done && !accept) begin
                overflow <= 1'b1;
            end
        end
    end

`ifdef COLLECTOR_TAG_CHECK_EN
    // Tag sequence checker: each accepted tag should be the previous
    // accepted tag + 1 (mod 256), starting from 0 after reset. Dropped
    // results are invisible to the checker.
    logic [7:0] expected_tag_reg;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            expected_tag_reg <= 8'h00;
            tag_seq_err      <= 1'b0;
        end else if (accept) begin
            expected_tag_reg <= InsTag_in + 8'h01;
            if (InsTag_in != expected_tag_reg) begin
                tag_seq_err <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_descale_result_collector.sv
// ---------------------------------------------------------------------------
// Testbench for descale_result_collector (DEPTH = 8).
// Stimulus is driven 1 time unit after each rising edge. A monitor samples at
// each falling edge, compares DUT state against a reference queue model and
// predicts the effect of the upcoming rising edge.
// ---------------------------------------------------------------------------
module tb_descale_result_collector;

    localparam int DEPTH = 8;

    logic        clock;
    logic        reset;
    logic [31:0] x_in, y_in, z_in;
    logic        done;
    logic [7:0]  InsTag_in;
    logic        ResultReady;
    logic [31:0] x_result, y_result, z_result;
    logic [7:0]  InsTagResult;
    logic        ResultValid;
    logic [$clog2(DEPTH):0] count;
    logic        full;
    logic        overflow;
`ifdef COLLECTOR_TAG_CHECK_EN
    logic        tag_seq_err;
`endif

    descale_result_collector #(.DEPTH(DEPTH)) dut (
        .clock        (clock),
        .reset        (reset),
        .x_in         (x_in),
        .y_in         (y_in),
        .z_in         (z_in),
        .done         (done),
        .InsTag_in    (InsTag_in),
        .ResultReady  (ResultReady),
        .x_result     (x_result),
        .y_result     (y_result),
        .z_result     (z_result),
        .InsTagResult (InsTagResult),
        .ResultValid  (ResultValid),
        .count        (count),
        .full         (full),
        .overflow     (overflow)
`ifdef COLLECTOR_TAG_CHECK_EN
        ,
        .tag_seq_err  (tag_seq_err)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    logic [103:0] sb [$];
    int           mcount = 0;
    bit           movf   = 1'b0;
`ifdef COLLECTOR_TAG_CHECK_EN
    logic [7:0]   mexp   = 8'h00;
    bit           merr   = 1'b0;
`endif

    task automatic check_value(input string tag, input logic [103:0] got,
                               input logic [103:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Monitor / scoreboard
    initial begin
        bit           mpop;
        logic [103:0] head;
        forever begin
            @(negedge clock);
            if (reset) begin
                sb.delete();
                mcount = 0;
                movf   = 1'b0;
`ifdef COLLECTOR_TAG_CHECK_EN
                mexp   = 8'h00;
                merr   = 1'b0;
`endif
            end else begin
                check_value("valid", 104'(ResultValid), 104'(mcount != 0));
                check_value("count", 104'(count), 104'(mcount));
                check_value("full", 104'(full), 104'(mcount == DEPTH));
                check_value("overflow", 104'(overflow), 104'(movf));
`ifdef COLLECTOR_TAG_CHECK_EN
                check_value("tag_seq_err", 104'(tag_seq_err), 104'(merr));
`endif
                head = {x_result, y_result, z_result, InsTagResult};
                if (mcount != 0) begin
                    check_value("head", head, sb[0]);
                end
                mpop = (mcount != 0) && ResultReady;
                if (mpop) begin
                    $display("pop  tag=%02h x=%08h y=%08h z=%08h count=%0d",
                             InsTagResult, x_result, y_result, z_result, count);
                    void'(sb.pop_front());
                end
                if (done) begin
                    if (mcount < DEPTH || mpop) begin
                        sb.push_back({x_in, y_in, z_in, InsTag_in});
                        mcount++;
`ifdef COLLECTOR_TAG_CHECK_EN
                        if (InsTag_in != mexp) merr = 1'b1;
                        mexp = InsTag_in + 8'h01;
`endif
                    end else begin
                        $display("drop tag=%02h", InsTag_in);
                        movf = 1'b1;
                    end
                end
                if (mpop) mcount--;
            end
        end
    end

    task automatic drive(input bit d, input logic [7:0] tag, input bit rdy,
                         input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] z);
        @(posedge clock);
        #1;
        done        = d;
        InsTag_in   = tag;
        ResultReady = rdy;
        x_in        = x;
        y_in        = y;
        z_in        = z;
    endtask

    task automatic push_rand(input logic [7:0] tag, input bit rdy);
        drive(1'b1, tag, rdy, $urandom, $urandom, $urandom);
    endtask

    task automatic idle(input bit rdy);
        drive(1'b0, 8'h00, rdy, 32'h0, 32'h0, 32'h0);
    endtask

    task automatic reset_pulse();
        @(posedge clock);
        #1;
        done  = 1'b0;
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_value({tag, "_x"}, 104'(x_result), 104'(0));
        check_value({tag, "_y"}, 104'(y_result), 104'(0));
        check_value({tag, "_z"}, 104'(z_result), 104'(0));
        check_value({tag, "_tag"}, 104'(InsTagResult), 104'(0));
        check_value({tag, "_valid"}, 104'(ResultValid), 104'(0));
        check_value({tag, "_count"}, 104'(count), 104'(0));
        check_value({tag, "_full"}, 104'(full), 104'(0));
        check_value({tag, "_ovf"}, 104'(overflow), 104'(0));
    endtask

    // Drain with ResultReady held high; bounded so a stuck DUT cannot hang.
    task automatic drain();
        for (int i = 0; i < 2 * DEPTH + 8; i++) begin
            idle(1'b1);
            if (sb.size() == 0 && !ResultValid) break;
        end
        check_value("drain_count", 104'(count), 104'(0));
        check_value("drain_valid", 104'(ResultValid), 104'(0));
    endtask

    initial begin
        reset       = 1'b1;
        done        = 1'b0;
        InsTag_in   = 8'h00;
        ResultReady = 1'b0;
        x_in        = 32'h0;
        y_in        = 32'h0;
        z_in        = 32'h0;
        repeat (3) @(posedge clock);
        #1;
        check_reset_outputs("por");
        reset = 1'b0;

        // Reset in the middle of a burst
        for (int i = 0; i < 5; i++) push_rand(8'(8'h10 + i), 1'b0);
        @(posedge clock);
        #3;
        reset     = 1'b1;
        done      = 1'b1;
        InsTag_in = 8'h77;
        #1;
        check_reset_outputs("midrst");
        @(posedge clock);
        #1;
        done  = 1'b0;
        reset = 1'b0;
        idle(1'b0);
        check_value("midrst_after_count", 104'(count), 104'(0));
        push_rand(8'h00, 1'b0);
        push_rand(8'h01, 1'b0);
        drain();

        // Single result, consumer ready
        reset_pulse();
        drive(1'b1, 8'h05, 1'b1, 32'h3F80_0000, 32'h4000_0000, 32'h0000_0000);
        idle(1'b1);
        check_value("single_valid", 104'(ResultValid), 104'(1));
        check_value("single_data", {x_result, y_result, z_result, InsTagResult},
                    {32'h3F80_0000, 32'h4000_0000, 32'h0000_0000, 8'h05});
        idle(1'b1);
        check_value("single_valid_off", 104'(ResultValid), 104'(0));
        check_value("single_count", 104'(count), 104'(0));

        // Backpressure fill, then one dropped result
        reset_pulse();
        for (int i = 0; i < DEPTH; i++) push_rand(8'(i), 1'b0);
        push_rand(8'h08, 1'b0);
        idle(1'b0);
        check_value("bp_full", 104'(full), 104'(1));
        check_value("bp_count", 104'(count), 104'(DEPTH));
        check_value("bp_overflow", 104'(overflow), 104'(1));
        idle(1'b0);
        check_value("bp_head_stable", 104'(InsTagResult), 104'(0));
        drain();
        check_value("bp_overflow_sticky", 104'(overflow), 104'(1));

        // Full FIFO with simultaneous push and pop
        reset_pulse();
        for (int i = 0; i < DEPTH; i++) push_rand(8'(i), 1'b0);
        push_rand(8'h20, 1'b1);
        idle(1'b0);
        check_value("fpp_count", 104'(count), 104'(DEPTH));
        check_value("fpp_overflow", 104'(overflow), 104'(0));
        drain();

        // Streaming across pointer wrap
        reset_pulse();
        for (int i = 0; i < 20; i++) push_rand(8'(i), 1'b1);
        drain();
        check_value("stream_overflow", 104'(overflow), 104'(0));

        // Tag sequence with a gap: 00, 01, 03
        reset_pulse();
        push_rand(8'h00, 1'b1);
        push_rand(8'h01, 1'b1);
        push_rand(8'h03, 1'b1);
        drain();
`ifdef COLLECTOR_TAG_CHECK_EN
        check_value("tagchk_set", 104'(tag_seq_err), 104'(1));
        idle(1'b1);
        check_value("tagchk_sticky", 104'(tag_seq_err), 104'(1));
`endif

        // Full tag cycle 00..FF then wrap to 00, streamed
        reset_pulse();
        for (int i = 0; i < 257; i++) push_rand(8'(i), 1'b1);
        drain();
`ifdef COLLECTOR_TAG_CHECK_EN
        check_value("tagchk_wrap_clean", 104'(tag_seq_err), 104'(0));
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
